// File: rtl/md_unit_pkg.sv
// Shared MIPS definitions used by the multiply/divide unit.
// Holds md_op encodings and default latencies.
package mips_defs;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_unit_if.sv
// EX-stage request / HI-LO result bundle between pipeline and md_unit.
interface md_unit_if;

    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, src_a, src_b,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b,
        output busy, md_stall, hi, lo
    );

endinterface

// File: rtl/md_unit_core.sv
// Combinational 64-bit product or {remainder, quotient}.
// Signed divide works on magnitudes, then restores signs.
module md_core (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    input  logic        is_div,
    output logic [63:0] result,
    output logic        dz
);

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] q;
    logic [31:0] r;

    always_comb begin
        ext_a = {{32{is_signed & a[31]}}, a};
        ext_b = {{32{is_signed & b[31]}}, b};
        // low 64 bits of the product are the same for signed and unsigned
        prod  = ext_a * ext_b;

        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;

        dz = is_div & (b == 32'd0);
        if (b == 32'd0) begin
            q_u = 32'd0;
            r_u = 32'd0;
        end else begin
            q_u = mag_a / mag_b;
            r_u = mag_a % mag_b;
        end

        // 0x80000000 / -1 falls out as q=0x80000000, r=0
        q = (neg_a ^ neg_b) ? (32'd0 - q_u) : q_u;
        r = neg_a ? (32'd0 - r_u) : r_u;

        result = is_div ? {r, q} : prod;
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// Result is computed at start and held pending until the count expires.
module md_unit
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave bus
);

    localparam int CW = 16;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t       state;
    state_t       state_n;
    logic [CW-1:0] ctr;
    logic [63:0]  pend;
    logic         pend_dz;
    logic [31:0]  hi_q;
    logic [31:0]  lo_q;

    logic         is_md;
    logic         is_div;
    logic         is_signed;
    logic [63:0]  core_res;
    logic         core_dz;

    logic         busy;
    logic         done;
    logic         load;
    logic         wr_hi;
    logic         wr_lo;

    assign is_md     = ~bus.md_op[2];
    assign is_div    = bus.md_op[1];
    assign is_signed = ~bus.md_op[0];

    md_core u_core (
        .a         (bus.src_a),
        .b         (bus.src_b),
        .is_signed (is_signed),
        .is_div    (is_div),
        .result    (core_res),
        .dz        (core_dz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.start && is_md) state_n = BUSY;
            BUSY: if (ctr == CW'(1))      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == BUSY);
        done  = busy && (ctr == CW'(1));
        load  = (state == IDLE) && bus.start && is_md;
        wr_hi = (state == IDLE) && bus.start && (bus.md_op == MD_MTHI);
        wr_lo = (state == IDLE) && bus.start && (bus.md_op == MD_MTLO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctr     <= '0;
            pend    <= '0;
            pend_dz <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (load) begin
                ctr     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                pend    <= core_res;
                pend_dz <= core_dz;
            end else if (busy) begin
                ctr <= ctr - CW'(1);
            end
            if (done && !pend_dz) begin
                hi_q <= pend[63:32];
                lo_q <= pend[31:0];
            end
            if (wr_hi) hi_q <= bus.src_a;
            if (wr_lo) lo_q <= bus.src_a;
        end
    end

    assign bus.busy     = busy;
    assign bus.md_stall = bus.start | busy;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed vector bench for md_unit: latency, HI/LO results, corner cases.
module tb_md_unit;
    import mips_defs::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   illegal_cnt = 0;

    md_unit_if bus();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // start presented while busy is a hazard-unit violation
    always @(posedge clk) begin
        if (!reset && bus.start && bus.busy) illegal_cnt <= illegal_cnt + 1;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t v[13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cyc,
                          output bit stable, output bit stall0);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = bus.hi;
        l0 = bus.lo;
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        #1 stall0 = bus.md_stall;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        stable = 1'b1;
        while (bus.busy && cyc < 100) begin
            cyc++;
            if (bus.hi !== h0 || bus.lo !== l0) stable = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int  cyc;
        bit  stable;
        bit  stall0;
        bit  aborted;

        v[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        v[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        v[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        v[3]  = '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        v[4]  = '{MD_MTHI,  32'h12345678, 32'h00000000, 32'h12345678, 32'h00000003, 0};
        v[5]  = '{MD_MTLO,  32'h9ABCDEF0, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 0};
        v[6]  = '{MD_DIV,   32'h00000005, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 10};
        v[7]  = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 10};
        v[8]  = '{3'd6,     32'h00000001, 32'h00000001, 32'h12345678, 32'h9ABCDEF0, 0};
        v[9]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        v[10] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        v[11] = '{MD_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 5};
        v[12] = '{MD_MULTU, 32'h7FFFFFFF, 32'h80000000, 32'h3FFFFFFF, 32'h80000000, 5};

        bus.start = 1'b0;
        bus.md_op = 3'd0;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset stall", {31'd0, bus.md_stall}, 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);

        for (int i = 0; i < 13; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, cyc, stable, stall0);
            check($sformatf("v%0d stall", i), {31'd0, stall0}, 32'd1);
            check($sformatf("v%0d cycles", i), cyc, v[i].cyc);
            check($sformatf("v%0d held", i), {31'd0, stable}, 32'd1);
            check($sformatf("v%0d hi", i), bus.hi, v[i].hi);
            check($sformatf("v%0d lo", i), bus.lo, v[i].lo);
        end

        check("no illegal start", illegal_cnt, 0);

        // mthi arriving on the third busy cycle of a div must be dropped
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = MD_DIV;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            if (cyc == 3) begin
                bus.start = 1'b1;
                bus.md_op = MD_MTHI;
                bus.src_a = 32'h0000DEAD;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("busy start cycles", cyc, 10);
        check("busy start seen", illegal_cnt, 1);
        check("busy start hi", bus.hi, 32'd2);
        check("busy start lo", bus.lo, 32'd14);

        // async reset in the fourth busy cycle of a mult
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = MD_MULT;
        bus.src_a = 32'd3;
        bus.src_b = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        aborted = 1'b0;
        while (bus.busy && cyc < 100 && !aborted) begin
            cyc++;
            if (cyc == 4) begin
                #2 reset = 1'b1;
                #1;
                check("rst busy", {31'd0, bus.busy}, 32'd0);
                check("rst hi", bus.hi, 32'd0);
                check("rst lo", bus.lo, 32'd0);
                aborted = 1'b1;
            end
            @(negedge clk);
        end
        check("rst reached", {31'd0, aborted}, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        run_op(MD_MULT, 32'd3, 32'd4, cyc, stable, stall0);
        check("post rst cycles", cyc, 5);
        check("post rst hi", bus.hi, 32'd0);
        check("post rst lo", bus.lo, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
